// File: rtl/nlfsr_seq_ctrl_pkg.sv
// Shared types and defaults for the NLFSR seeding / random-word controller.
package nlfsr_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_WARMUP,
    S_RUN
  } state_t;

  // Key / seed / NLFSR3 load word.
  typedef logic [4:0] word_t;

  localparam int DEF_SEED_WORDS    = 8;
  localparam int DEF_INIT_CYCLES   = 4;
  localparam int DEF_WARMUP_CYCLES = 64;
  localparam int DEF_OUT_W         = 8;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nlfsr_bit_packer.sv
// Collects mixed NLFSR bits LSB first into OUT_W-bit words and presents them
// through a valid/ready stage that stalls the NLFSRs while a word is pending.
module nlfsr_bit_packer
  import nlfsr_seq_ctrl_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic             rnd_ready,
  output logic             shift_ok,
  output logic [OUT_W-1:0] rnd_data,
  output logic             rnd_valid
);

  localparam int BW = cnt_width(OUT_W);

  logic [OUT_W-1:0] shift_reg;
  logic [BW-1:0]    bit_cnt;
  logic             shift_en;
  logic             word_done;
  logic             handshake;
  logic [OUT_W-1:0] shifted;

  // The generator may advance unless a finished word is waiting on the consumer;
  // on the handshake cycle itself it keeps running, so no bubble is inserted.
  assign shift_ok  = !(rnd_valid && !rnd_ready);
  assign shift_en  = en && shift_ok;
  assign word_done = shift_en && (bit_cnt == BW'(OUT_W - 1));
  assign handshake = rnd_valid && rnd_ready;
  assign shifted   = {bit_in, shift_reg[OUT_W-1:1]};

  // Shift register, bit counter and output word/valid register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
    end else if (clr) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      rnd_valid <= 1'b0;
    end else begin
      if (shift_en) begin
        shift_reg <= shifted;
        bit_cnt   <= word_done ? '0 : bit_cnt + BW'(1);
      end
      if (word_done) begin
        rnd_data  <= shifted;
        rnd_valid <= 1'b1;
      end else if (handshake) begin
        rnd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/nlfsr_seq_ctrl.sv
// Sequencer for three NLFSRs: captures the key, runs the init phase, streams
// seed words into the registers, discards a warm-up run, then packs the XOR
// of the three NLFSR outputs into random words with backpressure.
module nlfsr_seq_ctrl
  import nlfsr_seq_ctrl_pkg::*;
#(
  parameter int SEED_WORDS    = DEF_SEED_WORDS,
  parameter int INIT_CYCLES   = DEF_INIT_CYCLES,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int OUT_W         = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  word_t            tk_in,
  input  logic             seed_valid,
  input  word_t            seed_data,
  output logic             seed_ready,
  output logic             nlfsr_init,
  output logic             nlfsr_load,
  output logic             nlfsr_ce,
  output logic             d1,
  output logic             d2,
  output word_t            d3,
  output word_t            tk,
  input  logic             a0,
  input  logic             b0,
  input  logic             o_warbler,
  output logic [OUT_W-1:0] rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             busy
);

  localparam int CYC_MAX = max2(INIT_CYCLES, WARMUP_CYCLES);
  localparam int CW      = cnt_width(CYC_MAX);
  localparam int SW      = cnt_width(SEED_WORDS);

  state_t        state, state_next;
  logic [CW-1:0] cyc_cnt, cyc_next;
  logic [SW-1:0] seed_cnt, seed_next;
  logic          seed_hs;
  logic          run_state;
  logic          mix_bit;
  logic          shift_ok;

  assign seed_hs   = (state == S_LOAD) && seed_valid;
  assign run_state = (state == S_RUN);
  assign mix_bit   = a0 ^ b0 ^ o_warbler;
  assign busy      = (state != S_IDLE);

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cyc_cnt  <= '0;
      seed_cnt <= '0;
    end else begin
      state    <= state_next;
      cyc_cnt  <= cyc_next;
      seed_cnt <= seed_next;
    end
  end

  // Key capture on an accepted start; a simultaneous stop cancels the start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tk <= '0;
    end else if ((state == S_IDLE) && start && !stop) begin
      tk <= tk_in;
    end
  end

  // Next-state logic; counters restart from zero on every state entry.
  always_comb begin
    state_next = state;
    cyc_next   = cyc_cnt;
    seed_next  = seed_cnt;
    if (stop) begin
      state_next = S_IDLE;
      cyc_next   = '0;
      seed_next  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_next = S_INIT;
            cyc_next   = '0;
          end
        end
        S_INIT: begin
          if (cyc_cnt == CW'(INIT_CYCLES - 1)) begin
            state_next = S_LOAD;
            cyc_next   = '0;
            seed_next  = '0;
          end else begin
            cyc_next = cyc_cnt + CW'(1);
          end
        end
        S_LOAD: begin
          if (seed_hs) begin
            if (seed_cnt == SW'(SEED_WORDS - 1)) begin
              state_next = S_WARMUP;
              seed_next  = '0;
              cyc_next   = '0;
            end else begin
              seed_next = seed_cnt + SW'(1);
            end
          end
        end
        S_WARMUP: begin
          if (cyc_cnt == CW'(WARMUP_CYCLES - 1)) begin
            state_next = S_RUN;
            cyc_next   = '0;
          end else begin
            cyc_next = cyc_cnt + CW'(1);
          end
        end
        S_RUN: begin
          state_next = S_RUN;
        end
        default: begin
          state_next = S_IDLE;
          cyc_next   = '0;
          seed_next  = '0;
        end
      endcase
    end
  end

  // NLFSR control outputs decoded from state; load data only on a seed handshake.
  always_comb begin
    seed_ready = 1'b0;
    nlfsr_init = 1'b0;
    nlfsr_load = 1'b0;
    nlfsr_ce   = 1'b0;
    d1         = 1'b0;
    d2         = 1'b0;
    d3         = '0;
    case (state)
      S_INIT: begin
        nlfsr_init = 1'b1;
        nlfsr_ce   = 1'b1;
      end
      S_LOAD: begin
        seed_ready = 1'b1;
        if (seed_valid) begin
          nlfsr_load = 1'b1;
          nlfsr_ce   = 1'b1;
          d1         = seed_data[0];
          d2         = seed_data[1];
          d3         = seed_data;
        end
      end
      S_WARMUP: begin
        nlfsr_ce = 1'b1;
      end
      S_RUN: begin
        nlfsr_ce = shift_ok;
      end
      default: begin
        nlfsr_ce = 1'b0;
      end
    endcase
  end

  nlfsr_bit_packer #(
    .OUT_W(OUT_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (stop),
    .en       (run_state),
    .bit_in   (mix_bit),
    .rnd_ready(rnd_ready),
    .shift_ok (shift_ok),
    .rnd_data (rnd_data),
    .rnd_valid(rnd_valid)
  );

endmodule
